// File: rtl/delay_timer.sv
// Programmable countdown timer with prescaler, one-shot and auto-reload modes.
// Optional Pause input enabled by defining DELAY_TIMER_PAUSE_EN.
//
// state   | meaning
// IDLE    | stopped, Count=0, waiting for Start
// COUNT   | counting down one tick every PRESCALE clocks, Busy=1
// EXPIRED | one-shot expiry reached, Finished=1 until Start or Abort
module delay_timer #(
   parameter int WIDTH    = 12,
   parameter int PRESCALE = 1
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Start,
   input  logic             Abort,
   input  logic             Reload,
   input  logic [WIDTH-1:0] Delay,
`ifdef DELAY_TIMER_PAUSE_EN
   input  logic             Pause,
`endif
   output logic [WIDTH-1:0] Count,
   output logic             Busy,
   output logic             Finished,
   output logic             Done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   state_t      state;
   logic [15:0] prescaler;
   logic        mode_reload;
   logic        pause_w;

`ifdef DELAY_TIMER_PAUSE_EN
   assign pause_w = Pause;
`else
   assign pause_w = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state       <= IDLE;
         Count       <= '0;
         Busy        <= 1'b0;
         Finished    <= 1'b0;
         Done        <= 1'b0;
         prescaler   <= '0;
         mode_reload <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (Abort) begin
            state     <= IDLE;
            Count     <= '0;
            Busy      <= 1'b0;
            Finished  <= 1'b0;
            prescaler <= '0;
         end else if (Start) begin
            Count     <= Delay;
            prescaler <= '0;
            // a zero delay expires immediately and never reloads
            mode_reload <= Reload && (Delay != '0);
            if (Delay != '0) begin
               state    <= COUNT;
               Busy     <= 1'b1;
               Finished <= 1'b0;
            end else begin
               state    <= EXPIRED;
               Busy     <= 1'b0;
               Finished <= 1'b1;
               Done     <= 1'b1;
            end
         end else if (state == COUNT && !pause_w) begin
            if (prescaler == PS_LAST) begin
               prescaler <= '0;
               if (Count > WIDTH'(1)) begin
                  Count <= Count - WIDTH'(1);
               end else if (mode_reload && (Delay != '0)) begin
                  Done  <= 1'b1;
                  Count <= Delay;
               end else begin
                  Done     <= 1'b1;
                  Count    <= '0;
                  state    <= EXPIRED;
                  Busy     <= 1'b0;
                  Finished <= 1'b1;
               end
            end else begin
               prescaler <= prescaler + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_delay_timer.sv
// Directed self-checking bench for delay_timer; three instances with
// PRESCALE 1, 4 and 2 share the same stimulus.
module tb_delay_timer;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        Start = 1'b0;
   logic        Abort = 1'b0;
   logic        Reload = 1'b0;
   logic        Pause = 1'b0;
   logic [11:0] Delay = 12'd0;

   logic [11:0] count1, count4, count2;
   logic        busy1, busy4, busy2;
   logic        fin1, fin4, fin2;
   logic        done1, done4, done2;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 Clock = ~Clock;

   delay_timer #(.WIDTH(12), .PRESCALE(1)) dut1 (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort),
      .Reload(Reload), .Delay(Delay),
`ifdef DELAY_TIMER_PAUSE_EN
      .Pause(Pause),
`endif
      .Count(count1), .Busy(busy1), .Finished(fin1), .Done(done1));

   delay_timer #(.WIDTH(12), .PRESCALE(4)) dut4 (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort),
      .Reload(Reload), .Delay(Delay),
`ifdef DELAY_TIMER_PAUSE_EN
      .Pause(Pause),
`endif
      .Count(count4), .Busy(busy4), .Finished(fin4), .Done(done4));

   delay_timer #(.WIDTH(12), .PRESCALE(2)) dut2 (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort),
      .Reload(Reload), .Delay(Delay),
`ifdef DELAY_TIMER_PAUSE_EN
      .Pause(Pause),
`endif
      .Count(count2), .Busy(busy2), .Finished(fin2), .Done(done2));

   // advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic pulse_start(input logic [11:0] d, input logic rl);
      Delay = d;
      Reload = rl;
      Start = 1'b1;
      step();
      Start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total_cnt++;
      if ({count1, busy1, fin1, done1} !== 15'd0)
         $display("FAIL reset_outputs: got %h want 0", {count1, busy1, fin1, done1});
      else pass_cnt++;
      step();
      #3 Resetn = 1'b1;
      step();
      total_cnt++;
      if ({count4, busy4, fin4, done4} !== 15'd0)
         $display("FAIL reset_idle: got %h want 0", {count4, busy4, fin4, done4});
      else pass_cnt++;
   endtask

   task automatic test_oneshot();
      pulse_start(12'd5, 1'b0);
      for (int i = 0; i <= 5; i++) begin
         total_cnt++;
         if (count1 !== 12'(5 - i) || done1 !== (i == 5) || fin1 !== (i == 5) || busy1 !== (i != 5))
            $display("FAIL oneshot_step%0d: count=%0d done=%b fin=%b busy=%b want count=%0d done=%b",
                     i, count1, done1, fin1, busy1, 5 - i, (i == 5));
         else pass_cnt++;
         if (i < 5) step();
      end
      for (int i = 0; i < 3; i++) step();
      total_cnt++;
      if (done1 !== 1'b0 || fin1 !== 1'b1 || busy1 !== 1'b0 || count1 !== 12'd0)
         $display("FAIL oneshot_hold: done=%b fin=%b busy=%b count=%0d want 0 1 0 0",
                  done1, fin1, busy1, count1);
      else pass_cnt++;
   endtask

   task automatic test_reload();
      pulse_start(12'd3, 1'b1);
      for (int n = 1; n <= 56; n++) begin
         if (n == 37) Delay = 12'd2;
         step();
         total_cnt++;
         if (done4 !== (n == 12 || n == 24 || n == 36 || n == 48 || n == 56) || fin4 !== 1'b0 || busy4 !== 1'b1)
            $display("FAIL reload_edge%0d: done=%b fin=%b busy=%b want done=%b fin=0 busy=1",
                     n, done4, fin4, busy4, (n == 12 || n == 24 || n == 36 || n == 48 || n == 56));
         else pass_cnt++;
      end
      Reload = 1'b0;
      Abort = 1'b1;
      step();
      Abort = 1'b0;
   endtask

   task automatic test_zero_delay();
      pulse_start(12'd0, 1'b1);
      total_cnt++;
      if (done1 !== 1'b1 || fin1 !== 1'b1 || busy1 !== 1'b0 || count1 !== 12'd0)
         $display("FAIL zero_expire: done=%b fin=%b busy=%b count=%0d want 1 1 0 0",
                  done1, fin1, busy1, count1);
      else pass_cnt++;
      step();
      total_cnt++;
      if (done1 !== 1'b0 || fin1 !== 1'b1 || busy1 !== 1'b0)
         $display("FAIL zero_hold: done=%b fin=%b busy=%b want 0 1 0", done1, fin1, busy1);
      else pass_cnt++;
      Reload = 1'b0;
   endtask

   task automatic test_abort();
      int dones;
      pulse_start(12'd10, 1'b0);
      for (int i = 0; i < 6; i++) step();
      total_cnt++;
      if (count1 !== 12'd4)
         $display("FAIL abort_precount: count=%0d want 4", count1);
      else pass_cnt++;
      Abort = 1'b1;
      step();
      Abort = 1'b0;
      total_cnt++;
      if (count1 !== 12'd0 || busy1 !== 1'b0 || fin1 !== 1'b0 || done1 !== 1'b0)
         $display("FAIL abort_idle: count=%0d busy=%b fin=%b done=%b want 0 0 0 0",
                  count1, busy1, fin1, done1);
      else pass_cnt++;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done1 === 1'b1) dones++;
      end
      total_cnt++;
      if (dones != 0 || count1 !== 12'd0)
         $display("FAIL abort_no_done: dones=%0d count=%0d want 0 0", dones, count1);
      else pass_cnt++;
      pulse_start(12'd10, 1'b0);
      step();
      Abort = 1'b1;
      Start = 1'b1;
      step();
      Abort = 1'b0;
      Start = 1'b0;
      total_cnt++;
      if (count1 !== 12'd0 || busy1 !== 1'b0 || fin1 !== 1'b0)
         $display("FAIL abort_start_same: count=%0d busy=%b fin=%b want 0 0 0", count1, busy1, fin1);
      else pass_cnt++;
   endtask

   task automatic test_restart();
      pulse_start(12'd6, 1'b0);
      for (int i = 0; i < 5; i++) step();
      total_cnt++;
      if (count1 !== 12'd1)
         $display("FAIL restart_precount: count=%0d want 1", count1);
      else pass_cnt++;
      pulse_start(12'd6, 1'b0);
      total_cnt++;
      if (done1 !== 1'b0 || count1 !== 12'd6 || busy1 !== 1'b1)
         $display("FAIL restart_terminal: done=%b count=%0d busy=%b want 0 6 1", done1, count1, busy1);
      else pass_cnt++;
      for (int i = 1; i <= 6; i++) begin
         step();
         total_cnt++;
         if (done1 !== (i == 6))
            $display("FAIL restart_done%0d: done=%b want %b", i, done1, (i == 6));
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      pulse_start(12'd6, 1'b0);
      step();
      #3 Resetn = 1'b0;
      #1;
      total_cnt++;
      if ({count1, busy1, fin1, done1} !== 15'd0 || {count4, busy4, fin4, done4} !== 15'd0)
         $display("FAIL async_reset: dut1=%h dut4=%h want 0 0",
                  {count1, busy1, fin1, done1}, {count4, busy4, fin4, done4});
      else pass_cnt++;
      step();
      Resetn = 1'b1;
      step();
   endtask

`ifdef DELAY_TIMER_PAUSE_EN
   task automatic test_pause();
      pulse_start(12'd4, 1'b0);
      step();
      step();
      total_cnt++;
      if (count2 !== 12'd3)
         $display("FAIL pause_precount: count=%0d want 3", count2);
      else pass_cnt++;
      Pause = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         total_cnt++;
         if (count2 !== 12'd3 || busy2 !== 1'b1 || done2 !== 1'b0)
            $display("FAIL pause_hold%0d: count=%0d busy=%b done=%b want 3 1 0", i, count2, busy2, done2);
         else pass_cnt++;
      end
      Pause = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step();
         total_cnt++;
         if (done2 !== (i == 6))
            $display("FAIL pause_resume%0d: done=%b want %b", i, done2, (i == 6));
         else pass_cnt++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_oneshot();
      test_reload();
      test_zero_delay();
      test_abort();
      test_restart();
      test_async_reset();
`ifdef DELAY_TIMER_PAUSE_EN
      test_pause();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
